// File: rtl/flit_arbiter.sv
// Round-robin flit arbiter with packet locking toward a depacketizer.
// Optional LOCK idle timeout with abort flit: define FLIT_ARB_TIMEOUT_EN.
module flit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ*48-1:0]  req_flit,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [47:0]            flitoutde,
  output logic                   flit_valid,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   timeout_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state_reg;
  logic [IW-1:0]   rr_ptr_reg;
  logic [IW-1:0]   owner_reg;

`ifdef FLIT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   idle_cnt_reg;
`endif

  logic [47:0]     flits [NUM_REQ];
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic            acc;
  logic [IW-1:0]   acc_idx;
  logic [47:0]     acc_flit;
  logic            acc_tail;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Scan downward so the last hit is the one closest to rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[IW'((int'(rr_ptr_reg) + k) % NUM_REQ)]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(rr_ptr_reg) + k) % NUM_REQ);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign flits[gi]     = req_flit[48*gi +: 48];
      assign req_ready[gi] = reset && ((state_reg == LOCK) ? (owner_reg == IW'(gi))
                                                           : (win_found && (win_idx == IW'(gi))));
    end
  endgenerate

  assign acc      = |(req_ready & req_valid);
  assign acc_idx  = (state_reg == LOCK) ? owner_reg : win_idx;
  assign acc_flit = flits[acc_idx];
  assign acc_tail = (acc_flit[15:0] == 16'hFFFF);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      owner_reg    <= '0;
      flitoutde    <= '0;
      flit_valid   <= 1'b0;
      grant        <= '0;
      timeout_err  <= 1'b0;
`ifdef FLIT_ARB_TIMEOUT_EN
      idle_cnt_reg <= '0;
`endif
    end else begin
      flitoutde   <= '0;
      flit_valid  <= 1'b0;
      timeout_err <= 1'b0;
      if (acc) begin
        flitoutde  <= acc_flit;
        flit_valid <= 1'b1;
        grant      <= NUM_REQ'(1) << acc_idx;
`ifdef FLIT_ARB_TIMEOUT_EN
        idle_cnt_reg <= '0;
`endif
        if (acc_tail) begin
          state_reg  <= IDLE;
          rr_ptr_reg <= next_idx(acc_idx);
        end else begin
          state_reg <= LOCK;
          owner_reg <= acc_idx;
        end
      end else if (state_reg == LOCK) begin
`ifdef FLIT_ARB_TIMEOUT_EN
        // Forced release: emit the abort tail so the depacketizer closes the packet.
        if (idle_cnt_reg + 1'b1 == CW'(TIMEOUT)) begin
          flitoutde    <= {16'h0000, 16'h0000, 16'hFFFF};
          flit_valid   <= 1'b1;
          timeout_err  <= 1'b1;
          grant        <= '0;
          state_reg    <= IDLE;
          rr_ptr_reg   <= next_idx(owner_reg);
          idle_cnt_reg <= '0;
        end else begin
          idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
`endif
      end else begin
        grant <= '0;
      end
    end
  end

endmodule

// File: tb/tb_flit_arbiter.sv
// Bench for flit_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a packet-level reference model.
module tb_flit_arbiter;
  localparam int N  = 4;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N*48-1:0] req_flit = '0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [47:0]     flitoutde;
  logic            flit_valid;
  logic [N-1:0]    grant;
  logic            timeout_err;

  flit_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_flit(req_flit), .req_valid(req_valid),
    .req_ready(req_ready), .flitoutde(flitoutde), .flit_valid(flit_valid),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: packet ownership, round-robin pointer, idle count.
  bit          m_locked = 0;
  int          m_owner  = 0;
  int          m_ptr    = 0;
  int          m_cnt    = 0;
  bit          m_acc;
  int          m_idx;
  logic [N-1:0] m_ready;
  logic [47:0] e_flit  = '0;
  logic        e_valid = 0;
  logic [N-1:0] e_grant = '0;
  logic        e_err   = 0;
  logic [N-1:0] last_ready = '0;
  int          cycle = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endtask

  task automatic set_flit(input int i, input logic [15:0] h, input logic [15:0] p, input logic [15:0] e);
    req_flit[48*i +: 48] = {h, p, e};
  endtask

  task automatic model_comb();
    m_ready = '0; m_acc = 0; m_idx = 0;
    if (reset) begin
      if (m_locked) begin
        m_idx = m_owner; m_ready[m_owner] = 1'b1; m_acc = req_valid[m_owner];
      end else begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (!m_acc && req_valid[j]) begin
            m_acc = 1; m_idx = j; m_ready[j] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic model_seq();
    logic [47:0] f;
    e_err = 0;
    if (!reset) begin
      e_flit = '0; e_valid = 0; e_grant = '0;
      m_locked = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_acc) begin
      f = req_flit[48*m_idx +: 48];
      e_flit = f; e_valid = 1; e_grant = '0; e_grant[m_idx] = 1'b1; m_cnt = 0;
      if (f[15:0] == 16'hFFFF) begin
        m_locked = 0; m_ptr = (m_idx + 1) % N;
      end else begin
        m_locked = 1; m_owner = m_idx;
      end
    end else begin
      e_flit = '0; e_valid = 0;
      if (m_locked) begin
`ifdef FLIT_ARB_TIMEOUT_EN
        m_cnt++;
        if (m_cnt == TO) begin
          e_flit = 48'h0000_0000_FFFF; e_valid = 1; e_err = 1; e_grant = '0;
          m_locked = 0; m_ptr = (m_owner + 1) % N; m_cnt = 0;
        end
`endif
      end else begin
        e_grant = '0;
      end
    end
  endtask

  // One clock: check ready before the edge, all registered outputs after it.
  task automatic step();
    #1;
    model_comb();
    check("req_ready", 64'(req_ready), 64'(m_ready));
    last_ready = req_ready;
    model_seq();
    @(posedge clk);
    #1;
    cycle++;
    check("flitoutde", 64'(flitoutde), 64'(e_flit));
    check("flit_valid", 64'(flit_valid), 64'(e_valid));
    check("grant", 64'(grant), 64'(e_grant));
    check("timeout_err", 64'(timeout_err), 64'(e_err));
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // Reset with everyone valid.
    for (int i = 0; i < N; i++) set_flit(i, 16'h0010 + 16'(i), 16'h0020 + 16'(i), 16'hFFFF);
    req_valid = '1;
    reset = 0;
    repeat (2) begin
      step();
      check("rst_ready_lit", 64'(last_ready), 64'h0);
      check("rst_out_lit", 64'({flit_valid, grant, flitoutde}), 64'h0);
    end
    reset = 1;
    // Single-flit rotation 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      step();
      check("rot_grant_lit", 64'(grant), 64'(1 << (k % 4)));
      check("rot_flit_lit", 64'(flitoutde), {16'h0, 16'h0010 + 16'(k % 4), 16'h0020 + 16'(k % 4), 16'hFFFF});
    end
    req_valid = '0; reset = 0; step(); reset = 1;

    // Packet lock by requester 2 while requester 0 waits.
    req_valid = 4'b0010; set_flit(1, 16'h1, 16'h1, 16'hFFFF); step();
    set_flit(0, 16'h0, 16'h00C0, 16'hFFFF);
    set_flit(2, 16'h2, 16'h00A1, 16'h0000);
    req_valid = 4'b0101; step();
    check("lock_head_grant_lit", 64'(grant), 64'h4);
    check("lock_head_ready_lit", 64'(last_ready), 64'h4);
    set_flit(2, 16'h2, 16'h00A2, 16'h0000); step();
    check("lock_mid_ready0_lit", 64'(last_ready[0]), 64'h0);
    set_flit(2, 16'h2, 16'h00A3, 16'hFFFF);
    set_flit(3, 16'h3, 16'h00D3, 16'hFFFF);
    req_valid = 4'b1101; step();
    check("lock_tail_ready_lit", 64'(last_ready), 64'h4);
    req_valid = 4'b1001; step();
    check("after_lock_grant_lit", 64'(grant), 64'h8);
    check("after_lock_flit_lit", 64'(flitoutde), 64'h0003_00D3_FFFF);
    req_valid = 4'b0001; step();

    // Bubbles inside a packet from requester 1.
    set_flit(1, 16'h1, 16'h00B1, 16'h0000);
    req_valid = 4'b0010; step();
    req_valid = 4'b0001;
    repeat (3) begin
      step();
      check("bubble_valid_lit", 64'(flit_valid), 64'h0);
      check("bubble_grant_lit", 64'(grant), 64'h2);
      check("bubble_ready_lit", 64'(last_ready), 64'h2);
    end
    set_flit(1, 16'h1, 16'h00B2, 16'hFFFF);
    req_valid = 4'b0011; step();

    // Requester 3 locks and then stalls.
    set_flit(3, 16'h3, 16'h00E1, 16'h0000);
    req_valid = 4'b1001; step();
    check("to_head_grant_lit", 64'(grant), 64'h8);
    req_valid = 4'b0001;
`ifdef FLIT_ARB_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      step();
      if (k < TO) check("to_wait_grant_lit", 64'(grant), 64'h8);
    end
    check("to_abort_flit_lit", 64'(flitoutde), 64'h0000_0000_FFFF);
    check("to_abort_valid_lit", 64'(flit_valid), 64'h1);
    check("to_err_lit", 64'(timeout_err), 64'h1);
    check("to_grant_clear_lit", 64'(grant), 64'h0);
    step();
    check("to_next_grant_lit", 64'(grant), 64'h1);
    check("to_err_pulse_lit", 64'(timeout_err), 64'h0);
`else
    repeat (100) begin
      step();
      check("hold_grant_lit", 64'(grant), 64'h8);
      check("hold_err_lit", 64'(timeout_err), 64'h0);
    end
    set_flit(3, 16'h3, 16'h00E2, 16'hFFFF);
    req_valid = 4'b1001; step();
`endif
    req_valid = '0; reset = 0; step(); reset = 1;

    // Reset in the middle of a packet.
    set_flit(2, 16'h2, 16'h00F1, 16'h0000);
    req_valid = 4'b0100; step();
    req_valid = 4'b0101; reset = 0; step();
    check("mid_rst_valid_lit", 64'(flit_valid), 64'h0);
    check("mid_rst_grant_lit", 64'(grant), 64'h0);
    reset = 1; step();
    check("mid_rst_winner_lit", 64'(grant), 64'h1);

    // Random traffic; losers hold their flit until accepted.
    req_valid = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_ready[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          set_flit(i, 16'($urandom), 16'($urandom),
                   ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE)));
        end
      end
      reset = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
